kart_physics: RTL and testbench
===============================

KART_PHYSICS -- requirements
Module: kart_physics

Interface
REQ-001 Parameters SHALL be: MAX_SPEED=32, max forward speed in world units/frame; ACCEL=1, speed increment/frame; TURN_STEP=3, degrees per frame; START_X=1024; START_Y=1024; START_DIR=0.
REQ-002 clk_in  input  1  system clock.
REQ-003 rst_in  input  1  synchronous reset, active-low.
REQ-004 frame_in  input  1  one-cycle pulse, start of frame; triggers one update.
REQ-005 gas_in / brake_in / left_in / right_in  input  1 each  debounced controller levels.
REQ-006 terrain_in  input  4  track tile type under the kart (0 = road).
REQ-007 direction  output  9  heading, 0..359 degrees; 0 = up, +y world.
REQ-008 player_x / player_y  output  11 each  kart world position, 0..2047.
REQ-009 speed_out  output  6  current speed, 0..MAX_SPEED.
REQ-010 busy_out  output  1  update in progress.
REQ-011 update_valid_out  output  1  one-cycle pulse when new direction/position are committed.

Function
REQ-012 FSM states SHALL be IDLE, STEER, LOOK0, LOOK1, MOVE, COMMIT; each non-IDLE state lasts exactly one cycle, in that order, then back to IDLE.
REQ-013 In IDLE, frame_in=1 SHALL latch all five button/terrain inputs and go to STEER; frame_in in any other state SHALL be ignored.
REQ-014 STEER heading: left only -> dir-TURN_STEP; right only -> dir+TURN_STEP; both or neither -> unchanged; wrap mod 360 (0 left -> 357, 358 right -> 1).
REQ-015 STEER speed: brake (wins over gas) -> speed-2*ACCEL; gas only -> speed+ACCEL; neither -> speed-1; result clamped to 0..speed cap.
REQ-016 Speed cap SHALL be MAX_SPEED (see REQ-025 for terrain override).
REQ-017 Internal sin/cos ROMs (360 x 11-bit signed, round(512*sin/cos)) SHALL be addressed with the new heading; ROM read latency 2 cycles covered by LOOK0/LOOK1.
REQ-018 Position SHALL be held as 11-bit integer + 9-bit fraction per axis; MOVE computes x_fx -= speed*sin, y_fx += speed*cos (signed, full width, no truncation before add).
REQ-019 COMMIT SHALL clamp each axis integer to 0..2047; on any clamp, that axis fraction := 0 and speed := 0 (wall hit).
REQ-020 direction, player_x, player_y, speed_out SHALL change only in the COMMIT cycle, all together; held otherwise.
REQ-021 update_valid_out SHALL pulse high exactly 5 cycles after the cycle frame_in is sampled in IDLE.
REQ-022 busy_out SHALL be high in STEER through COMMIT inclusive, low in IDLE.

Reset
REQ-023 rst_in=0 at a clock edge SHALL force IDLE, direction=START_DIR, player_x=START_X, player_y=START_Y, fractions=0, speed_out=0, busy_out=0, update_valid_out=0.
REQ-024 Reset mid-update SHALL abort with no partial commit; first frame_in after release starts a fresh update.

Configuration
REQ-025 With OFFROAD_SLOW_EN defined, latched terrain_in != 0 SHALL make the speed cap MAX_SPEED/2 (speed above it clamped down in STEER); without it, terrain_in SHALL be ignored and cap is always MAX_SPEED.

Verification
REQ-026 Reset, dir 0, gas held 4 frames -> speed_out 1,2,3,4; player_y 1025,1027,1030,1034; player_x 1024; direction 0.
REQ-027 Reset, left held 1 frame -> direction 357; then right held 2 frames -> 0, then 3; both held -> unchanged.
REQ-028 Reach speed 4 at dir 90 (sin=512) -> player_x decreases by 4 per coasting-adjusted frame; brake+gas together -> speed drops by 2.
REQ-029 START_Y=2046, gas from reset -> player_y clamps at 2047, speed_out returns to 0 on clamp frame.
REQ-030 frame_in pulses at cycles 0 and 2 -> single update_valid_out at cycle 5, second pulse ignored; rst_in low at cycle 3 -> no valid pulse, outputs equal start values.
REQ-031 OFFROAD_SLOW_EN defined, terrain_in=1, gas held 40 frames -> speed_out saturates at 16; undefined -> saturates at 32.

Source files
------------

// File: rtl/kart_physics.sv
// kart_physics: once per frame, steers, accelerates and moves the kart, then commits the new pose.
// Define OFFROAD_SLOW_EN to halve the speed cap while the latched terrain is not road.
module kart_physics #(
    parameter int MAX_SPEED = 32,
    parameter int ACCEL     = 1,
    parameter int TURN_STEP = 3,
    parameter int START_X   = 1024,
    parameter int START_Y   = 1024,
    parameter int START_DIR = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_in,
    input  logic        gas_in,
    input  logic        brake_in,
    input  logic        left_in,
    input  logic        right_in,
    input  logic [3:0]  terrain_in,
    output logic [8:0]  direction,
    output logic [10:0] player_x,
    output logic [10:0] player_y,
    output logic [5:0]  speed_out,
    output logic        busy_out,
    output logic        update_valid_out
);

    typedef enum logic [2:0] {IDLE, STEER, LOOK0, LOOK1, MOVE, COMMIT} state_t;

    localparam logic signed [7:0] ACCEL_S = 8'(ACCEL);
    localparam logic signed [7:0] BRAKE_S = 8'(2 * ACCEL);

    state_t state, state_next;

    logic        gas_q, brake_q, left_q, right_q;
    logic [8:0]  dir_new;
    logic [5:0]  speed_new;
    logic [8:0]  x_frac, y_frac;
    logic signed [22:0] x_sum, y_sum;

    logic [9:0]  sin_mag, cos_mag;
    logic        sin_mag_neg, cos_mag_neg;
    logic signed [10:0] sin_val, cos_val;

    // One quadrant of round(512*sin(deg)); the full 360-entry tables are folded onto it.
    function automatic logic [9:0] quarter_sin(input logic [6:0] deg);
        case (deg)
            7'd0:  quarter_sin = 10'd0;   7'd1:  quarter_sin = 10'd9;   7'd2:  quarter_sin = 10'd18;
            7'd3:  quarter_sin = 10'd27;  7'd4:  quarter_sin = 10'd36;  7'd5:  quarter_sin = 10'd45;
            7'd6:  quarter_sin = 10'd54;  7'd7:  quarter_sin = 10'd62;  7'd8:  quarter_sin = 10'd71;
            7'd9:  quarter_sin = 10'd80;  7'd10: quarter_sin = 10'd89;  7'd11: quarter_sin = 10'd98;
            7'd12: quarter_sin = 10'd106; 7'd13: quarter_sin = 10'd115; 7'd14: quarter_sin = 10'd124;
            7'd15: quarter_sin = 10'd133; 7'd16: quarter_sin = 10'd141; 7'd17: quarter_sin = 10'd150;
            7'd18: quarter_sin = 10'd158; 7'd19: quarter_sin = 10'd167; 7'd20: quarter_sin = 10'd175;
            7'd21: quarter_sin = 10'd183; 7'd22: quarter_sin = 10'd192; 7'd23: quarter_sin = 10'd200;
            7'd24: quarter_sin = 10'd208; 7'd25: quarter_sin = 10'd216; 7'd26: quarter_sin = 10'd224;
            7'd27: quarter_sin = 10'd232; 7'd28: quarter_sin = 10'd240; 7'd29: quarter_sin = 10'd248;
            7'd30: quarter_sin = 10'd256; 7'd31: quarter_sin = 10'd264; 7'd32: quarter_sin = 10'd271;
            7'd33: quarter_sin = 10'd279; 7'd34: quarter_sin = 10'd286; 7'd35: quarter_sin = 10'd294;
            7'd36: quarter_sin = 10'd301; 7'd37: quarter_sin = 10'd308; 7'd38: quarter_sin = 10'd315;
            7'd39: quarter_sin = 10'd322; 7'd40: quarter_sin = 10'd329; 7'd41: quarter_sin = 10'd336;
            7'd42: quarter_sin = 10'd343; 7'd43: quarter_sin = 10'd349; 7'd44: quarter_sin = 10'd356;
            7'd45: quarter_sin = 10'd362; 7'd46: quarter_sin = 10'd368; 7'd47: quarter_sin = 10'd374;
            7'd48: quarter_sin = 10'd380; 7'd49: quarter_sin = 10'd386; 7'd50: quarter_sin = 10'd392;
            7'd51: quarter_sin = 10'd398; 7'd52: quarter_sin = 10'd403; 7'd53: quarter_sin = 10'd409;
            7'd54: quarter_sin = 10'd414; 7'd55: quarter_sin = 10'd419; 7'd56: quarter_sin = 10'd424;
            7'd57: quarter_sin = 10'd429; 7'd58: quarter_sin = 10'd434; 7'd59: quarter_sin = 10'd439;
            7'd60: quarter_sin = 10'd443; 7'd61: quarter_sin = 10'd448; 7'd62: quarter_sin = 10'd452;
            7'd63: quarter_sin = 10'd456; 7'd64: quarter_sin = 10'd460; 7'd65: quarter_sin = 10'd464;
            7'd66: quarter_sin = 10'd468; 7'd67: quarter_sin = 10'd471; 7'd68: quarter_sin = 10'd475;
            7'd69: quarter_sin = 10'd478; 7'd70: quarter_sin = 10'd481; 7'd71: quarter_sin = 10'd484;
            7'd72: quarter_sin = 10'd487; 7'd73: quarter_sin = 10'd490; 7'd74: quarter_sin = 10'd492;
            7'd75: quarter_sin = 10'd495; 7'd76: quarter_sin = 10'd497; 7'd77: quarter_sin = 10'd499;
            7'd78: quarter_sin = 10'd501; 7'd79: quarter_sin = 10'd503; 7'd80: quarter_sin = 10'd504;
            7'd81: quarter_sin = 10'd506; 7'd82: quarter_sin = 10'd507; 7'd83: quarter_sin = 10'd508;
            7'd84: quarter_sin = 10'd509; 7'd85: quarter_sin = 10'd510; 7'd86: quarter_sin = 10'd511;
            7'd87: quarter_sin = 10'd511; 7'd88: quarter_sin = 10'd512; 7'd89: quarter_sin = 10'd512;
            7'd90: quarter_sin = 10'd512;
            default: quarter_sin = 10'd0;
        endcase
    endfunction

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_in) state_next = STEER;
            STEER:   state_next = LOOK0;
            LOOK0:   state_next = LOOK1;
            LOOK1:   state_next = MOVE;
            MOVE:    state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy_out = (state != IDLE);

    // Speed cap; terrain only matters when off-road slowdown is built in.
    logic [5:0] cap;
`ifdef OFFROAD_SLOW_EN
    logic [3:0] terrain_q;
    assign cap = (terrain_q != 4'd0) ? 6'(MAX_SPEED / 2) : 6'(MAX_SPEED);
`else
    logic unused_terrain;
    assign unused_terrain = ^terrain_in;
    assign cap = 6'(MAX_SPEED);
`endif

    logic [8:0]  dir_calc, dir_sum;
    logic signed [7:0] spd_base, spd_calc;
    logic [5:0]  spd_lim;

    always_comb begin
        dir_calc = direction;
        dir_sum  = direction + 9'(TURN_STEP);
        if (left_q && !right_q)
            dir_calc = (direction < 9'(TURN_STEP)) ? direction + 9'(360 - TURN_STEP)
                                                   : direction - 9'(TURN_STEP);
        else if (right_q && !left_q)
            dir_calc = (dir_sum >= 9'd360) ? dir_sum - 9'd360 : dir_sum;

        spd_base = $signed({2'b00, speed_out});
        if (brake_q)
            spd_calc = spd_base - BRAKE_S;
        else if (gas_q)
            spd_calc = spd_base + ACCEL_S;
        else
            spd_calc = spd_base - 8'sd1;

        if (spd_calc < 8'sd0)
            spd_lim = 6'd0;
        else if (spd_calc > $signed({2'b00, cap}))
            spd_lim = cap;
        else
            spd_lim = spd_calc[5:0];
    end

    // Fold the new heading onto the quarter table for both sine and cosine.
    logic [6:0] sin_idx, cos_idx;
    logic       sin_neg, cos_neg;

    always_comb begin
        sin_idx = 7'd0;
        cos_idx = 7'd0;
        sin_neg = 1'b0;
        cos_neg = 1'b0;
        if (dir_new <= 9'd90) begin
            sin_idx = dir_new[6:0];
            cos_idx = 7'(9'd90 - dir_new);
        end else if (dir_new <= 9'd180) begin
            sin_idx = 7'(9'd180 - dir_new);
            cos_idx = 7'(dir_new - 9'd90);
            cos_neg = 1'b1;
        end else if (dir_new <= 9'd270) begin
            sin_idx = 7'(dir_new - 9'd180);
            cos_idx = 7'(9'd270 - dir_new);
            sin_neg = 1'b1;
            cos_neg = 1'b1;
        end else begin
            sin_idx = 7'(9'd360 - dir_new);
            cos_idx = 7'(dir_new - 9'd270);
            sin_neg = 1'b1;
        end
    end

    logic signed [22:0] x_cur, y_cur, spd_ext, sin_ext, cos_ext;
    assign x_cur   = $signed({3'b000, player_x, x_frac});
    assign y_cur   = $signed({3'b000, player_y, y_frac});
    assign spd_ext = $signed({17'd0, speed_new});
    assign sin_ext = $signed({{12{sin_val[10]}}, sin_val});
    assign cos_ext = $signed({{12{cos_val[10]}}, cos_val});

    // Leaving the 0..2047 world on an axis pins that axis to the edge and stops the kart.
    logic [10:0] x_int_c, y_int_c;
    logic [8:0]  x_frac_c, y_frac_c;
    logic        x_wall, y_wall;

    always_comb begin
        x_int_c  = x_sum[19:9];
        x_frac_c = x_sum[8:0];
        x_wall   = 1'b0;
        y_int_c  = y_sum[19:9];
        y_frac_c = y_sum[8:0];
        y_wall   = 1'b0;
        if (x_sum[22]) begin
            x_int_c = 11'd0; x_frac_c = 9'd0; x_wall = 1'b1;
        end else if (x_sum[21:20] != 2'd0) begin
            x_int_c = 11'd2047; x_frac_c = 9'd0; x_wall = 1'b1;
        end
        if (y_sum[22]) begin
            y_int_c = 11'd0; y_frac_c = 9'd0; y_wall = 1'b1;
        end else if (y_sum[21:20] != 2'd0) begin
            y_int_c = 11'd2047; y_frac_c = 9'd0; y_wall = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            gas_q            <= 1'b0;
            brake_q          <= 1'b0;
            left_q           <= 1'b0;
            right_q          <= 1'b0;
`ifdef OFFROAD_SLOW_EN
            terrain_q        <= 4'd0;
`endif
            dir_new          <= 9'(START_DIR);
            speed_new        <= 6'd0;
            x_sum            <= 23'sd0;
            y_sum            <= 23'sd0;
            sin_mag          <= 10'd0;
            cos_mag          <= 10'd0;
            sin_mag_neg      <= 1'b0;
            cos_mag_neg      <= 1'b0;
            sin_val          <= 11'sd0;
            cos_val          <= 11'sd0;
            direction        <= 9'(START_DIR);
            player_x         <= 11'(START_X);
            player_y         <= 11'(START_Y);
            x_frac           <= 9'd0;
            y_frac           <= 9'd0;
            speed_out        <= 6'd0;
            update_valid_out <= 1'b0;
        end else begin
            state            <= state_next;
            update_valid_out <= 1'b0;

            // Two-stage table read: magnitude lookup, then sign applied.
            sin_mag     <= quarter_sin(sin_idx);
            cos_mag     <= quarter_sin(cos_idx);
            sin_mag_neg <= sin_neg;
            cos_mag_neg <= cos_neg;
            sin_val     <= sin_mag_neg ? -$signed({1'b0, sin_mag}) : $signed({1'b0, sin_mag});
            cos_val     <= cos_mag_neg ? -$signed({1'b0, cos_mag}) : $signed({1'b0, cos_mag});

            case (state)
                IDLE: if (frame_in) begin
                    gas_q     <= gas_in;
                    brake_q   <= brake_in;
                    left_q    <= left_in;
                    right_q   <= right_in;
`ifdef OFFROAD_SLOW_EN
                    terrain_q <= terrain_in;
`endif
                end
                STEER: begin
                    dir_new   <= dir_calc;
                    speed_new <= spd_lim;
                end
                MOVE: begin
                    x_sum <= x_cur - spd_ext * sin_ext;
                    y_sum <= y_cur + spd_ext * cos_ext;
                end
                COMMIT: begin
                    direction        <= dir_new;
                    player_x         <= x_int_c;
                    player_y         <= y_int_c;
                    x_frac           <= x_frac_c;
                    y_frac           <= y_frac_c;
                    speed_out        <= (x_wall || y_wall) ? 6'd0 : speed_new;
                    update_valid_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kart_physics.sv
// tb_kart_physics: directed frames against hand-computed kart pose, speed and timing values.
// A second instance starts next to the top wall to exercise the clamp path.
module tb_kart_physics;

    logic        clk_in = 1'b0;
    logic        rst_in, frame_in, gas_in, brake_in, left_in, right_in;
    logic [3:0]  terrain_in;

    logic [8:0]  direction, e_direction;
    logic [10:0] player_x, player_y, e_player_x, e_player_y;
    logic [5:0]  speed_out, e_speed_out;
    logic        busy_out, update_valid_out, e_busy_out, e_update_valid_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    kart_physics dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_in(frame_in),
        .gas_in(gas_in), .brake_in(brake_in), .left_in(left_in), .right_in(right_in),
        .terrain_in(terrain_in), .direction(direction), .player_x(player_x),
        .player_y(player_y), .speed_out(speed_out), .busy_out(busy_out),
        .update_valid_out(update_valid_out)
    );

    kart_physics #(.START_Y(2046)) edge_dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_in(frame_in),
        .gas_in(gas_in), .brake_in(brake_in), .left_in(left_in), .right_in(right_in),
        .terrain_in(terrain_in), .direction(e_direction), .player_x(e_player_x),
        .player_y(e_player_y), .speed_out(e_speed_out), .busy_out(e_busy_out),
        .update_valid_out(e_update_valid_out)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d required %0d", tag, observed, expected);
        end
    endtask

    task automatic reset_dut();
        rst_in     = 1'b0;
        frame_in   = 1'b0;
        gas_in     = 1'b0;
        brake_in   = 1'b0;
        left_in    = 1'b0;
        right_in   = 1'b0;
        terrain_in = 4'd0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    // Runs one frame from a negedge and returns at the negedge where update_valid_out is seen.
    task automatic apply_stimulus(input logic gas, input logic brake, input logic left,
                                  input logic right, input logic [3:0] terr);
        int edges;
        gas_in     = gas;
        brake_in   = brake;
        left_in    = left;
        right_in   = right;
        terrain_in = terr;
        frame_in   = 1'b1;
        @(posedge clk_in);
        #1 frame_in = 1'b0;
        edges = 0;
        do begin
            @(posedge clk_in);
            edges++;
            @(negedge clk_in);
        end while (!update_valid_out && edges < 12);
        check_output("valid_latency", edges, 5);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_speed [4];
        int exp_y     [4];
        int exp_x     [4];
        int e_speed   [4];
        int pulses;
        int first;
        int cap_exp;
        int y_exp;

        exp_speed = '{1, 2, 3, 4};
        exp_y     = '{1025, 1027, 1030, 1034};
        exp_x     = '{1023, 1021, 1018, 1014};
        e_speed   = '{1, 0, 0, 0};

        // Reset state
        reset_dut();
        check_output("rst_dir", direction, 0);
        check_output("rst_x", player_x, 1024);
        check_output("rst_y", player_y, 1024);
        check_output("rst_speed", speed_out, 0);
        check_output("rst_busy", busy_out, 0);
        check_output("rst_valid", update_valid_out, 0);
        check_output("rst_edge_y", e_player_y, 2046);

        // Straight-line acceleration, and the wall clamp on the edge instance
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
            check_output("gas_speed", speed_out, exp_speed[i]);
            check_output("gas_y", player_y, exp_y[i]);
            check_output("gas_x", player_x, 1024);
            check_output("gas_dir", direction, 0);
            check_output("edge_y", e_player_y, 2047);
            check_output("edge_speed", e_speed_out, e_speed[i]);
        end

        // Steering wrap in both directions and the both-pressed case
        reset_dut();
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_output("left_wrap", direction, 357);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        check_output("right_wrap", direction, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        check_output("right_step", direction, 3);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        check_output("both_hold", direction, 3);
        check_output("steer_speed", speed_out, 0);
        check_output("steer_x", player_x, 1024);
        check_output("steer_y", player_y, 1024);

        // Heading 90: motion is along -x only
        reset_dut();
        repeat (30) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        check_output("dir90", direction, 90);
        check_output("dir90_x", player_x, 1024);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
            check_output("d90_speed", speed_out, exp_speed[i]);
            check_output("d90_x", player_x, exp_x[i]);
            check_output("d90_y", player_y, 1024);
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check_output("coast_speed", speed_out, 3);
        check_output("coast_x", player_x, 1011);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        check_output("brake_speed", speed_out, 1);
        check_output("brake_x", player_x, 1010);

        // Frame pulses at cycles 0 and 2: exactly one commit, at cycle 5
        reset_dut();
        gas_in   = 1'b1;
        frame_in = 1'b1;
        @(posedge clk_in);
        #1 frame_in = 1'b0;
        @(posedge clk_in);
        #1 check_output("busy_mid", busy_out, 1);
        @(negedge clk_in);
        frame_in = 1'b1;
        @(posedge clk_in);
        #1 frame_in = 1'b0;
        pulses = 0;
        first  = 0;
        for (int k = 3; k <= 12; k++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (update_valid_out) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        check_output("valid_pulses", pulses, 1);
        check_output("valid_cycle", first, 5);
        check_output("busy_after", busy_out, 0);
        check_output("single_speed", speed_out, 1);
        check_output("single_y", player_y, 1025);

        // Reset at cycle 3 aborts the update without committing
        reset_dut();
        gas_in   = 1'b1;
        frame_in = 1'b1;
        @(posedge clk_in);
        #1 frame_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        frame_in = 1'b1;
        @(posedge clk_in);
        #1 frame_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (update_valid_out) pulses++;
        end
        check_output("abort_pulses", pulses, 0);
        check_output("abort_dir", direction, 0);
        check_output("abort_x", player_x, 1024);
        check_output("abort_y", player_y, 1024);
        check_output("abort_speed", speed_out, 0);
        check_output("abort_busy", busy_out, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check_output("fresh_speed", speed_out, 1);
        check_output("fresh_y", player_y, 1025);

        // Off-road: 40 gas frames saturate at the active cap
`ifdef OFFROAD_SLOW_EN
        cap_exp = 16;
        y_exp   = 1544;
`else
        cap_exp = 32;
        y_exp   = 1808;
`endif
        reset_dut();
        repeat (40) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        check_output("cap_speed", speed_out, cap_exp);
        check_output("cap_y", player_y, y_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
